// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one external comparator among NREQ requesters.
// Define CMP_SHARE_STATS_EN to add saturating per-result handshake counters.
module cmp_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [DW-1:0]     cmp_a,
    output logic [DW-1:0]     cmp_b,
    input  logic              cmp_eq,
    input  logic              cmp_gt,
    input  logic              cmp_lt,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_eq,
    output logic              resp_gt,
    output logic              resp_lt,
    output logic              resp_err
`ifdef CMP_SHARE_STATS_EN
    ,
    output logic [15:0]       stat_eq,
    output logic [15:0]       stat_gt,
    output logic [15:0]       stat_lt
`endif
);
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
    state_t state, state_nxt;
    logic [IDW-1:0] ptr, gnt;
    logic accept;
    // Descending scan so the lowest offset from ptr wins.
    always_comb begin
        gnt = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(ptr) + k) % NREQ]) gnt = IDW'((int'(ptr) + k) % NREQ);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (|req_valid ? EVAL : IDLE) :
                    state == EVAL ? RESP :
                    (resp_ready ? IDLE : RESP);
    end
    always_comb begin
        accept     = state == IDLE && |req_valid;
        req_ready  = accept ? NREQ'(1) << gnt : '0;
        resp_valid = state == RESP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            cmp_a    <= '0;
            cmp_b    <= '0;
            resp_id  <= '0;
            resp_eq  <= 1'b0;
            resp_gt  <= 1'b0;
            resp_lt  <= 1'b0;
            resp_err <= 1'b0;
        end else if (accept) begin
            cmp_a   <= req_a[gnt*DW +: DW];
            cmp_b   <= req_b[gnt*DW +: DW];
            resp_id <= gnt;
            ptr     <= gnt == IDW'(NREQ - 1) ? '0 : gnt + 1'b1;
        end else if (state == EVAL) begin
            resp_eq  <= cmp_eq;
            resp_gt  <= cmp_gt;
            resp_lt  <= cmp_lt;
            resp_err <= ~(cmp_eq ^ cmp_gt ^ cmp_lt) | (cmp_eq & cmp_gt & cmp_lt);
        end
    end
`ifdef CMP_SHARE_STATS_EN
    logic hs;
    assign hs = resp_valid & resp_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_eq <= '0;
            stat_gt <= '0;
            stat_lt <= '0;
        end else if (hs) begin
            stat_eq <= stat_eq + 16'(resp_eq && stat_eq != 16'hFFFF);
            stat_gt <= stat_gt + 16'(resp_gt && stat_gt != 16'hFFFF);
            stat_lt <= stat_lt + 16'(resp_lt && stat_lt != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: scoreboard bench with a transaction-level round-robin model.
module tb_cmp_share_arbiter;
    localparam int N = 4, DW = 4;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*DW-1:0] req_a = '0, req_b = '0;
    logic [DW-1:0] cmp_a, cmp_b;
    logic cmp_eq, cmp_gt, cmp_lt, resp_valid, resp_ready = 0;
    logic [1:0] resp_id;
    logic resp_eq, resp_gt, resp_lt, resp_err;
    logic force_err = 0, rr_rand = 0;
`ifdef CMP_SHARE_STATS_EN
    logic [15:0] stat_eq, stat_gt, stat_lt;
`endif
    // External comparator; force_err makes eq and gt both assert.
    assign cmp_eq = force_err | (cmp_a == cmp_b);
    assign cmp_gt = force_err | (cmp_a > cmp_b);
    assign cmp_lt = !force_err & (cmp_a < cmp_b);

    cmp_share_arbiter #(.NREQ(N), .DW(DW), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
        .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_eq(resp_eq), .resp_gt(resp_gt), .resp_lt(resp_lt),
        .resp_err(resp_err)
`ifdef CMP_SHARE_STATS_EN
        , .stat_eq(stat_eq), .stat_gt(stat_gt), .stat_lt(stat_lt)
`endif
    );

    typedef struct {int id; bit eq, gt, lt, err; int cyc;} exp_t;
    exp_t q[$];
    exp_t cur, e;
    int checks = 0, errors = 0, cyc = 0, ptr = 0, g;
    int n_eq = 0, n_gt = 0, n_lt = 0;
    bit busy = 0, have_cur = 0;
    logic [DW-1:0] ma, mb;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rr_rand) #1 resp_ready = 1'($urandom_range(0, 1));

    // Model: one transaction in flight; grant the first valid requester at or after ptr.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            busy <= 0;
            ptr = 0;
        end else if (!busy && req_valid != 0) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (req_valid[(ptr + k) % N]) begin
                    g = (ptr + k) % N;
                    break;
                end
            chk("req_ready_grant", int'(req_ready), 1 << g);
            ma = req_a[g*DW +: DW];
            mb = req_b[g*DW +: DW];
            e.id = g;
            e.eq = force_err || ma == mb;
            e.gt = force_err || ma > mb;
            e.lt = !force_err && ma < mb;
            e.err = force_err;
            e.cyc = cyc + 2;
            q.push_back(e);
            ptr = (g + 1) % N;
            busy <= 1;
        end else chk("req_ready_none", int'(req_ready), 0);
    end

    // Monitor: pop on each new response and hold-check it every cycle until accepted.
    always @(negedge clk) begin
        if (rst) begin
            have_cur = 0;
            n_eq = 0; n_gt = 0; n_lt = 0;
        end else if (resp_valid) begin
            if (!have_cur) begin
                chk("resp_has_request", q.size() > 0 ? 1 : 0, 1);
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    have_cur = 1;
                    chk("latency", cyc, cur.cyc);
                end
            end
            if (have_cur) begin
                chk("resp_id", int'(resp_id), cur.id);
                chk("resp_eq", int'(resp_eq), int'(cur.eq));
                chk("resp_gt", int'(resp_gt), int'(cur.gt));
                chk("resp_lt", int'(resp_lt), int'(cur.lt));
                chk("resp_err", int'(resp_err), int'(cur.err));
            end
            if (resp_ready) begin
                if (have_cur) begin
                    n_eq += int'(cur.eq); n_gt += int'(cur.gt); n_lt += int'(cur.lt);
                end
                have_cur = 0;
                busy <= 0;
            end
        end
    end

    task automatic run(input logic [N-1:0] m, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        logic [N-1:0] acc;
        int t = 0;
        req_a = a; req_b = b; req_valid = m;
        while (req_valid != 0 && t < 200) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~acc;
            t++;
        end
        chk("grant_timeout", int'(req_valid), 0);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || busy) && t < 100) begin
            @(posedge clk); t++;
        end
        #1 chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int t;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_cmp_ab", int'({cmp_a, cmp_b}), 0);
        chk("rst_resp_bits", int'({resp_id, resp_eq, resp_gt, resp_lt, resp_err}), 0);
        @(posedge clk); #1 rst = 0;
        repeat (10) @(posedge clk);
        #1 resp_ready = 1;
        run(4'b0001, 16'h0005, 16'h0005); drain();
        run(4'b1111, 16'h9999, 16'h3333); drain();
        run(4'b0001, 16'h0009, 16'h0003); drain();
        resp_ready = 0;
        run(4'b0100, 16'h0200, 16'h0F00);
        repeat (7) @(posedge clk);
        #1 resp_ready = 1; drain();
        force_err = 1;
        run(4'b0010, 16'h0070, 16'h0010); drain();
        force_err = 0;
        // Abandon a transaction by resetting while it sits in EVAL.
        req_a = 16'h000C; req_b = 16'h0004; req_valid = 4'b0001; t = 0;
        do begin
            @(negedge clk); t++;
        end while (!req_ready[0] && t < 20);
        chk("abort_grant", int'(req_ready[0]), 1);
        @(posedge clk); #1 req_valid = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        repeat (6) @(negedge clk);
        chk("abort_no_resp", int'(resp_valid), 0);
        run(4'b1000, 16'h1000, 16'h1000); drain();
        rr_rand = 1;
        repeat (400) begin
            @(posedge clk); #1;
            req_valid = N'($urandom_range(0, 15));
            req_a = 16'($urandom);
            req_b = 16'($urandom_range(0, 3) == 0 ? req_a : 16'($urandom));
        end
        req_valid = 0; rr_rand = 0;
        @(posedge clk); #2 resp_ready = 1;
        drain();
`ifdef CMP_SHARE_STATS_EN
        @(negedge clk);
        chk("stat_eq", int'(stat_eq), n_eq);
        chk("stat_gt", int'(stat_gt), n_gt);
        chk("stat_lt", int'(stat_lt), n_lt);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
